demorgan_sweep_checker: RTL



---
 rtl/demorgan_sweep_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/demorgan_sweep_checker.sv
// De Morgan checker over an N-bit vector: live manual mode from switches or a paced sweep of all 2^N vectors.
// Optional build macro FAULT_INJECT_EN adds a fault_inj input that corrupts y2 at v==0.
module demorgan_sweep_checker #(
    parameter int N       = 2,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         mode,
    input  logic         start,
`ifdef FAULT_INJECT_EN
    input  logic         fault_inj,
`endif
    output logic         redled,
    output logic         greenled,
    output logic         blueled,
    output logic         done,
    output logic         busy,
    output logic [N-1:0] vec,
    output logic [N:0]   fail_cnt
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [PW-1:0] psc;
    logic [N-1:0]  sw_m, sw_s;
    logic          mode_m, mode_s, start_m, start_s, start_d;
    logic          fi_s;
    logic          start_pulse, step, last;
    logic          y1, y2, y3, y4, ok;
    logic [N:0]    fail_nx;

`ifdef FAULT_INJECT_EN
    logic fi_m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fi_m <= 1'b0;
            fi_s <= 1'b0;
        end else begin
            fi_m <= fault_inj;
            fi_s <= fi_m;
        end
    end
`else
    assign fi_s = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m    <= '0;
            sw_s    <= '0;
            mode_m  <= 1'b0;
            mode_s  <= 1'b0;
            start_m <= 1'b0;
            start_s <= 1'b0;
            start_d <= 1'b0;
        end else begin
            sw_m    <= sw;
            sw_s    <= sw_m;
            mode_m  <= mode;
            mode_s  <= mode_m;
            start_m <= start;
            start_s <= start_m;
            start_d <= start_s;
        end
    end

    assign start_pulse = start_s & ~start_d;

    // The injected fault flips only y2, and only for the all-zero vector.
    assign y1      = ~|vec;
    assign y2      = (&(~vec)) ^ (fi_s & (vec == '0));
    assign y3      = ~&vec;
    assign y4      = |(~vec);
    assign ok      = (y1 == y2) && (y3 == y4);
    assign step    = (psc == PW'(CLK_DIV - 1));
    assign last    = (vec == '1);
    assign fail_nx = fail_cnt + {{N{1'b0}}, ~ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            psc      <= '0;
            vec      <= '0;
            fail_cnt <= '0;
            redled   <= 1'b0;
            greenled <= 1'b0;
            blueled  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            redled   <= y1;
            greenled <= y3;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!mode_s) begin
                        vec     <= sw_s;
                        blueled <= ok;
                    end else begin
                        blueled <= 1'b0;
                        if (start_pulse) begin
                            state    <= SWEEP;
                            vec      <= '0;
                            fail_cnt <= '0;
                            psc      <= '0;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    blueled <= 1'b0;
                    if (!mode_s) begin
                        // Abort keeps the partial fail count for inspection.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        psc <= step ? '0 : psc + 1'b1;
                        if (step) begin
                            fail_cnt <= fail_nx;
                            if (last) begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                blueled <= (fail_nx == '0);
                            end else begin
                                vec <= vec + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!mode_s) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start_pulse) begin
                        state    <= SWEEP;
                        vec      <= '0;
                        fail_cnt <= '0;
                        psc      <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        blueled  <= 1'b0;
                    end else begin
                        blueled <= (fail_cnt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
